fetch_stage: RTL and testbench

Instruction-fetch front end for the pipelined CPU. It owns the PC, issues one instruction-memory request at a time over a request/response handshake, and writes the IF/ID pipeline register consumed by decode. It honours a stall from the hazard unit and a redirect from branch/jump resolution, which also flushes IF/ID.

---
 rtl/fetch_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction-fetch front end: PC, single-outstanding imem
//            request/response handshake, and the IF/ID pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcout,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pcadd4
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  localparam logic [31:0] C_ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_hold_buf;
  logic [31:0] w_hold_nxt;
  logic        w_deliver;
  logic [31:0] w_deliver_instr;
  logic        w_fire;
  logic [31:0] w_redirect_aligned;
  logic [31:0] w_pc_plus4;

  assign w_redirect_aligned = redirect_pc & C_ALIGN_MASK;
  assign w_pc_plus4         = r_pc + 32'd4;
  assign imem_req           = (r_state == S_REQ);
  assign w_fire             = imem_req & imem_ready;
  assign pcout              = r_pc;
  assign imem_addr          = r_pc;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_hold_nxt      = r_hold_buf;
    w_deliver       = 1'b0;
    w_deliver_instr = r_hold_buf;
    case (r_state)
      // Any response seen here belongs to a request abandoned by reset.
      S_REQ: begin
        if (redirect) w_pc_nxt = w_redirect_aligned;
        if (w_fire)   w_state_nxt = redirect ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (redirect) begin
            w_pc_nxt    = w_redirect_aligned;
            w_state_nxt = S_REQ;
          end else if (!stall) begin
            w_deliver       = 1'b1;
            w_deliver_instr = imem_rdata;
            w_pc_nxt        = w_pc_plus4;
            w_state_nxt     = S_REQ;
          end else begin
            w_hold_nxt  = imem_rdata;
            w_state_nxt = S_HOLD;
          end
        end else if (redirect) begin
          w_pc_nxt    = w_redirect_aligned;
          w_state_nxt = S_DROP;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          w_pc_nxt    = w_redirect_aligned;
          w_state_nxt = S_REQ;
        end else if (!stall) begin
          w_deliver   = 1'b1;
          w_pc_nxt    = w_pc_plus4;
          w_state_nxt = S_REQ;
        end
      end
      // The in-flight response is for a wrong-path PC; swallow it.
      S_DROP: begin
        if (redirect)    w_pc_nxt    = w_redirect_aligned;
        if (imem_rvalid) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC & C_ALIGN_MASK;
      r_hold_buf <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_hold_buf <= w_hold_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ifid_valid  <= 1'b0;
      ifid_instr  <= NOP_INSTR;
      ifid_pc     <= '0;
      ifid_pcadd4 <= '0;
    end else if (redirect) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
    end else if (stall) begin
      ifid_valid <= ifid_valid;
    end else if (w_deliver) begin
      ifid_valid  <= 1'b1;
      ifid_instr  <= w_deliver_instr;
      ifid_pc     <= r_pc;
      ifid_pcadd4 <= w_pc_plus4;
    end else begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed self-checking bench for fetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect, imem_ready, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, ifid_valid;
  logic [31:0] imem_addr, pcout, ifid_instr, ifid_pc, ifid_pcadd4;

  // Second instance exercises the PC wrap at the top of the address space.
  logic        w_ready, w_rvalid;
  logic [31:0] w_rdata;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_pcout, w_instr, w_pc, w_pcadd4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pcout(pcout), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc), .ifid_pcadd4(ifid_pcadd4)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(w_ready), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .pcout(w_pcout), .ifid_valid(w_valid), .ifid_instr(w_instr),
    .ifid_pc(w_pc), .ifid_pcadd4(w_pcadd4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    w_ready = 1'b0; w_rvalid = 1'b0; w_rdata = '0;

    tick(); tick();
    rst = 1'b1;
    check("rst_req",    {31'b0, imem_req},   32'd1);
    check("rst_addr",   imem_addr,           32'h0);
    check("rst_valid",  {31'b0, ifid_valid}, 32'd0);
    check("rst_instr",  ifid_instr,          32'h0);
    check("rst_pc",     ifid_pc,             32'h0);
    check("rst_pcadd4", ifid_pcadd4,         32'h0);
    check("rst_waddr",  w_addr,              32'hFFFF_FFFC);

    // Streaming: fire, respond next cycle, twice.
    imem_ready = 1'b1;
    tick();
    check("s1_req_wait", {31'b0, imem_req}, 32'd0);
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2001_0005;
    tick();
    check("s1_valid",  {31'b0, ifid_valid}, 32'd1);
    check("s1_instr",  ifid_instr,  32'h2001_0005);
    check("s1_pc",     ifid_pc,     32'h0);
    check("s1_pcadd4", ifid_pcadd4, 32'h4);
    check("s1_addr",   imem_addr,   32'h4);
    imem_rvalid = 1'b0; imem_ready = 1'b1;
    tick();
    check("s2_bubble_valid", {31'b0, ifid_valid}, 32'd0);
    check("s2_bubble_instr", ifid_instr, 32'h0);
    check("s2_bubble_pc",    ifid_pc,    32'h0);
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2002_000A;
    tick();
    check("s2_valid",  {31'b0, ifid_valid}, 32'd1);
    check("s2_instr",  ifid_instr,  32'h2002_000A);
    check("s2_pc",     ifid_pc,     32'h4);
    check("s2_pcadd4", ifid_pcadd4, 32'h8);

    // Stall: request still fires, response parks in the hold buffer.
    imem_rvalid = 1'b0; imem_ready = 1'b1; stall = 1'b1;
    tick();
    check("st_fire_valid", {31'b0, ifid_valid}, 32'd1);
    check("st_fire_instr", ifid_instr, 32'h2002_000A);
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3003_000F;
    for (int i = 0; i < 3; i++) begin
      tick();
      imem_rvalid = 1'b0;
      check("st_req",   {31'b0, imem_req}, 32'd0);
      check("st_instr", ifid_instr, 32'h2002_000A);
      check("st_pc",    ifid_pc,    32'h4);
      check("st_addr",  imem_addr,  32'h8);
    end
    stall = 1'b0;
    tick();
    check("st_rel_valid",  {31'b0, ifid_valid}, 32'd1);
    check("st_rel_instr",  ifid_instr,  32'h3003_000F);
    check("st_rel_pc",     ifid_pc,     32'h8);
    check("st_rel_pcadd4", ifid_pcadd4, 32'hC);
    check("st_rel_addr",   imem_addr,   32'hC);

    // Redirect while waiting for a response.
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0043;
    tick();
    redirect = 1'b0;
    check("rw_valid", {31'b0, ifid_valid}, 32'd0);
    check("rw_instr", ifid_instr, 32'h0);
    check("rw_req",   {31'b0, imem_req}, 32'd0);
    check("rw_addr",  imem_addr, 32'h40);
    tick();
    check("rw_drop_req", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("rw_after_req",   {31'b0, imem_req}, 32'd1);
    check("rw_after_addr",  imem_addr, 32'h40);
    check("rw_after_valid", {31'b0, ifid_valid}, 32'd0);
    check("rw_after_instr", ifid_instr, 32'h0);

    // Load a valid instruction, then hit redirect+stall+rvalid together.
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_0040;
    tick();
    check("rs_pre_instr", ifid_instr, 32'h1111_0040);
    check("rs_pre_pc",    ifid_pc,    32'h40);
    imem_rvalid = 1'b0; imem_ready = 1'b1; stall = 1'b1;
    tick();
    check("rs_held_valid", {31'b0, ifid_valid}, 32'd1);
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    imem_rvalid = 1'b0; redirect = 1'b0; stall = 1'b0;
    check("rs_valid", {31'b0, ifid_valid}, 32'd0);
    check("rs_instr", ifid_instr, 32'h0);
    check("rs_req",   {31'b0, imem_req}, 32'd1);
    check("rs_addr",  pcout, 32'h100);

    // PC wrap on the second instance.
    w_ready = 1'b1;
    tick();
    check("wr_req_wait", {31'b0, w_req}, 32'd0);
    w_ready = 1'b0; w_rvalid = 1'b1; w_rdata = 32'h2400_0001;
    tick();
    w_rvalid = 1'b0;
    check("wr_valid",  {31'b0, w_valid}, 32'd1);
    check("wr_instr",  w_instr,  32'h2400_0001);
    check("wr_pc",     w_pc,     32'hFFFF_FFFC);
    check("wr_pcadd4", w_pcadd4, 32'h0);
    check("wr_addr",   w_addr,   32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
